filt_sched: RTL

FILT_SCHED -- requirements
Module: filt_sched

---
 rtl/filt_sched_pkg.sv | 19 +
 rtl/filt_pos_tracker.sv | 67 ++++++
 rtl/filt_sched.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/filt_sched_pkg.sv
// Shared types and constants for the filter scheduler and its position tracker.
package filt_sched_pkg;

  localparam int EN_WIDTH = 4;
  localparam int SEC_W    = 3;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    RUN       = 2'd1,
    HOLD      = 2'd2
  } state_t;

  typedef logic [1:0] phase_t;

  function automatic logic [EN_WIDTH-1:0] onehot_en(input phase_t idx);
    return {{(EN_WIDTH-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/filt_pos_tracker.sv
// Tracks pixel/line position of each transfer beat and maps it to a section index.
module filt_pos_tracker
  import filt_sched_pkg::*;
#(
  parameter int XResolution  = 1939,
  parameter int YResolution  = 1120,
  parameter int XNumSections = 4,
  parameter int YNumSections = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             xfer_i,
  input  logic             frame_start_i,
  input  logic             line_end_i,
  input  logic             vde_i,
  output logic [SEC_W-1:0] x_sec_o,
  output logic [SEC_W-1:0] y_sec_o
);

  localparam int XW    = (XResolution > 1) ? $clog2(XResolution) : 1;
  localparam int YW    = (YResolution > 1) ? $clog2(YResolution) : 1;
  localparam int XSecW = XResolution / XNumSections;
  localparam int YSecH = YResolution / YNumSections;
  localparam logic [XW-1:0] X_MAX = XW'(XResolution - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(YResolution - 1);

  logic [XW-1:0] x_q, x_cur, x_d;
  logic [YW-1:0] y_q, y_cur, y_d;
  logic [31:0]   x_div, y_div;

  // Coordinates of the current beat; a frame start overrides a simultaneous line end.
  always_comb begin
    x_cur = x_q;
    y_cur = y_q;
    if (frame_start_i) begin
      x_cur = '0;
      y_cur = '0;
    end else if (line_end_i) begin
      x_cur = '0;
      y_cur = (y_q == Y_MAX) ? y_q : y_q + YW'(1);
    end
    x_d = x_q;
    y_d = y_q;
    if (xfer_i) begin
      x_d = x_cur;
      y_d = y_cur;
      if (vde_i && (x_cur != X_MAX)) x_d = x_cur + XW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // The last section absorbs any remainder of the uneven division.
  assign x_div   = 32'(x_cur) / 32'(XSecW);
  assign y_div   = 32'(y_cur) / 32'(YSecH);
  assign x_sec_o = (x_div >= 32'(XNumSections)) ? SEC_W'(XNumSections - 1) : x_div[SEC_W-1:0];
  assign y_sec_o = (y_div >= 32'(YNumSections)) ? SEC_W'(YNumSections - 1) : y_div[SEC_W-1:0];

endmodule

// File: rtl/filt_sched.sv
// Rotating filter-enable scheduler driven by the video pipeline handshake.
// Button pause/step control is compiled only when FILT_SCHED_BTN_EN is defined.
module filt_sched
  import filt_sched_pkg::*;
#(
  parameter int XResolution   = 1939,
  parameter int YResolution   = 1120,
  parameter int XNumSections  = 4,
  parameter int YNumSections  = 4,
  parameter int FramesPerStep = 60
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  input  logic                ready_i,
  input  logic                hsync_i,
  input  logic                vsync_i,
  input  logic                vde_i,
  input  logic [1:0]          btn_i,
  output logic [EN_WIDTH-1:0] enable_o,
  output logic [1:0]          phase_o,
  output logic                paused_o
);

  localparam int FCW = (FramesPerStep > 1) ? $clog2(FramesPerStep) : 1;
  localparam logic [FCW-1:0] FC_LAST = FCW'(FramesPerStep - 1);

  logic                xfer, frame_start, line_end;
  logic                vsync_q, vde_q;
  logic                pause_rise, step_rise;
  logic [SEC_W-1:0]    x_sec, y_sec;
  state_t              state_q, state_d;
  logic [FCW-1:0]      frame_cnt_q, frame_cnt_d;
  phase_t              phase_q, phase_d, pend_q, pend_d, sel;
  logic [EN_WIDTH-1:0] en_q, en_d;
  logic                unused_sig;

  assign xfer        = valid_i && ready_i;
  assign frame_start = xfer && vsync_i && !vsync_q;
  assign line_end    = xfer && !vde_i && vde_q;
  assign unused_sig  = hsync_i ^ x_sec[SEC_W-1] ^ y_sec[SEC_W-1];

  filt_pos_tracker #(
    .XResolution (XResolution),
    .YResolution (YResolution),
    .XNumSections(XNumSections),
    .YNumSections(YNumSections)
  ) u_pos (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .xfer_i       (xfer),
    .frame_start_i(frame_start),
    .line_end_i   (line_end),
    .vde_i        (vde_i),
    .x_sec_o      (x_sec),
    .y_sec_o      (y_sec)
  );

`ifdef FILT_SCHED_BTN_EN
  logic [1:0] btn_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) btn_q <= '0;
    else         btn_q <= btn_i;
  end

  // Pause toggle wins over a step that rises in the same cycle.
  assign pause_rise = btn_i[0] && !btn_q[0];
  assign step_rise  = btn_i[1] && !btn_q[1] && !pause_rise;
  assign paused_o   = (state_q == HOLD);
`else
  logic unused_btn;
  assign unused_btn = ^btn_i;
  assign pause_rise = 1'b0;
  assign step_rise  = 1'b0;
  assign paused_o   = 1'b0;
`endif

  // Steps taken in HOLD accumulate in pend and only land on the phase at a frame start.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    pend_d      = pend_q;
    en_d        = en_q;
    sel         = '0;
    if (frame_start) begin
      phase_d = phase_q + pend_q;
      pend_d  = '0;
    end
    case (state_q)
      WAIT_SYNC: begin
        if (frame_start) state_d = RUN;
      end
      RUN: begin
        if (frame_start) begin
          if (frame_cnt_q == FC_LAST) begin
            frame_cnt_d = '0;
            phase_d     = phase_d + 2'd1;
          end else begin
            frame_cnt_d = frame_cnt_q + FCW'(1);
          end
        end
        if (pause_rise) state_d = HOLD;
      end
      HOLD: begin
        if (pause_rise) begin
          state_d     = RUN;
          frame_cnt_d = '0;
        end else if (step_rise) begin
          pend_d = pend_d + 2'd1;
        end
      end
      default: state_d = WAIT_SYNC;
    endcase
    if (xfer) begin
      sel  = x_sec[1:0] + y_sec[1:0] + phase_d;
      en_d = (state_d == WAIT_SYNC) ? '0 : onehot_en(sel);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= WAIT_SYNC;
      frame_cnt_q <= '0;
      phase_q     <= '0;
      pend_q      <= '0;
      en_q        <= '0;
      vsync_q     <= 1'b0;
      vde_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
      pend_q      <= pend_d;
      en_q        <= en_d;
      if (xfer) begin
        vsync_q <= vsync_i;
        vde_q   <= vde_i;
      end
    end
  end

  assign enable_o = en_q;
  assign phase_o  = phase_q;

endmodule
